// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states and stage control bundle.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_DROP = 2'd2
    } fetch_state_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_BUSY = 1'b1
    } dmem_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_flush;
    } stage_ctrl_t;

    // Everything frozen, every bubble-capable stage loading a bubble.
    localparam stage_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
        id_ex_flush: 1'b1, ex_mem_en: 1'b0, mem_wb_en: 1'b0, mem_wb_flush: 1'b1
    };

    // Free-flowing pipeline.
    localparam stage_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_flush: 1'b0
    };

    // True when an ID source operand is read and matches the EX destination.
    function automatic logic src_hits(input logic                 uses,
                                      input logic [REG_IDX_W-1:0] src,
                                      input logic [REG_IDX_W-1:0] rd);
        return uses && (src == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fetch_skid.sv
// Fetch sequencer: one outstanding imem request, response drop after redirect, 1-entry skid.
module pipe_hazard_ctrl_fetch_skid
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic            accept,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            imem_req_c,
    output logic            inst_avail_c,
    output logic [XLEN-1:0] inst_c
);

    fetch_state_e    state_q, state_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_data_q, skid_data_d;
    logic            rsp_live;

    // State and skid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= F_REQ;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Next state, skid update and fetch-side outputs.
    always_comb begin
        state_d      = state_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        imem_req_c   = 1'b0;

        rsp_live     = (state_q == F_WAIT) && !skid_valid_q && imem_rvalid;
        inst_avail_c = skid_valid_q || rsp_live;
        inst_c       = skid_valid_q ? skid_data_q : (rsp_live ? imem_rdata : '0);

        unique case (state_q)
            // A redirect retargets the PC this cycle, so the request waits for the new address.
            F_REQ: begin
                imem_req_c = !redirect;
                if (!redirect) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (redirect) begin
                    skid_valid_d = 1'b0;
                    state_d      = inst_avail_c ? F_REQ : F_DROP;
                end else if (inst_avail_c) begin
                    if (accept) begin
                        skid_valid_d = 1'b0;
                        state_d      = F_REQ;
                    end else if (!skid_valid_q) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = imem_rdata;
                    end
                end
            end
            F_DROP: begin
                if (imem_rvalid) begin
                    state_d = F_REQ;
                end
            end
            default: state_d = F_REQ;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: hazard priority, stage enables/flushes, perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1_idx,
    input  logic [REG_IDX_W-1:0] id_rs2_idx,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd_idx,
    input  logic                 ex_mem_ren,
    input  logic                 ex_redirect,
    input  logic                 mem_access,
    input  logic                 dmem_done,
    input  logic                 imem_rvalid,
    input  logic [XLEN-1:0]      imem_rdata,
    output logic                 imem_req,
    output logic                 fetch_valid,
    output logic [XLEN-1:0]      fetch_inst,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_wb_flush,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    logic            dstall;
    logic            load_use;
    logic            redirect_take;
    logic            accept;
    logic            inst_avail;
    logic            imem_req_raw;
    logic [XLEN-1:0] inst_raw;
    stage_ctrl_t     ctrl;
    stage_ctrl_t     ctrl_live;
    dmem_state_e     dmem_state_q, dmem_state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Hazard terms; a redirect is held back while MEM freezes the front of the pipe.
    always_comb begin
        dstall        = mem_access && !dmem_done;
        load_use      = ex_mem_ren && (ex_rd_idx != '0) &&
                        (src_hits(id_uses_rs1, id_rs1_idx, ex_rd_idx) ||
                         src_hits(id_uses_rs2, id_rs2_idx, ex_rd_idx));
        redirect_take = ex_redirect && !dstall;
    end

    // Priority: dstall > redirect > load-use > fetch wait > normal.
    always_comb begin
        ctrl_live = CTRL_RUN;
        if (dstall) begin
            ctrl_live.pc_en        = 1'b0;
            ctrl_live.if_id_en     = 1'b0;
            ctrl_live.id_ex_en     = 1'b0;
            ctrl_live.ex_mem_en    = 1'b0;
            ctrl_live.mem_wb_flush = 1'b1;
        end else if (redirect_take) begin
            ctrl_live.if_id_flush  = 1'b1;
            ctrl_live.id_ex_flush  = 1'b1;
        end else if (load_use) begin
            ctrl_live.pc_en        = 1'b0;
            ctrl_live.if_id_en     = 1'b0;
            ctrl_live.id_ex_flush  = 1'b1;
        end else if (!inst_avail) begin
            ctrl_live.pc_en        = 1'b0;
            ctrl_live.if_id_flush  = 1'b1;
        end
        accept = ctrl_live.if_id_en && !ctrl_live.if_id_flush;
    end

    // Outputs show their reset values for as long as rst_n is held low.
    always_comb begin
        ctrl         = rst_n ? ctrl_live : CTRL_RESET;
        imem_req     = rst_n && imem_req_raw;
        fetch_valid  = rst_n && inst_avail;
        fetch_inst   = rst_n ? inst_raw : '0;
        pc_en        = ctrl.pc_en;
        if_id_en     = ctrl.if_id_en;
        id_ex_en     = ctrl.id_ex_en;
        ex_mem_en    = ctrl.ex_mem_en;
        mem_wb_en    = ctrl.mem_wb_en;
        if_id_flush  = ctrl.if_id_flush;
        id_ex_flush  = ctrl.id_ex_flush;
        mem_wb_flush = ctrl.mem_wb_flush;
        stall_cnt    = stall_cnt_q;
        flush_cnt    = flush_cnt_q;
    end

    // Data-memory wait tracking, next state.
    always_comb begin
        dmem_state_d = dmem_state_q;
        unique case (dmem_state_q)
            D_IDLE:  if (dstall)    dmem_state_d = D_BUSY;
            D_BUSY:  if (dmem_done) dmem_state_d = D_IDLE;
            default: dmem_state_d = D_IDLE;
        endcase
    end

    // Data FSM register and wrapping performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_state_q <= D_IDLE;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            dmem_state_q <= dmem_state_d;
            if (!ctrl_live.pc_en) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_take) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    pipe_hazard_ctrl_fetch_skid #(
        .XLEN (XLEN)
    ) u_fetch_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect_take),
        .accept       (accept),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .imem_req_c   (imem_req_raw),
        .inst_avail_c (inst_avail),
        .inst_c       (inst_raw)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage RV32I pipeline. Drives per-stage enable and flush for PC, IF-ID, ID-EX, EX-MEM and MEM-WB.
- Handles load-use stalls, EX-stage redirects, variable-latency instruction fetch with a 1-entry skid buffer, and data-memory wait states.
- Sits beside the datapath; the datapath stage registers obey its enables and flushes.

Parameters:
- XLEN, 32, datapath width (from CPU_profile)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- id_rs1_idx  in  5  rs1 of instruction in ID
- id_rs2_idx  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd_idx  in  5  rd of instruction in EX (ID-EX bus)
- ex_mem_ren  in  1  EX instruction is a load
- ex_redirect  in  1  EX branch taken or jump; PC target valid
- mem_access  in  1  MEM-stage instruction has mem_ren or mem_wen
- dmem_done  in  1  data memory completes the access this cycle
- imem_rvalid  in  1  instruction response valid
- imem_rdata  in  32  instruction response data
- imem_req  out  1  one-cycle fetch request at current PC
- fetch_valid  out  1  fetch_inst is valid for capture into IF-ID
- fetch_inst  out  32  instruction to IF-ID
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register load enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, reg_wen=0, mem_ren/wen=0)
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  number of redirects taken

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - fetch FSM = F_REQ; data FSM = D_IDLE
  - skid empty; counters 0
  - all enables 0; all flushes 1
  - imem_req 0; fetch_valid 0; fetch_inst 0
- Condition terms:
  - dstall = mem_access && !dmem_done. Data FSM is D_IDLE→D_BUSY on dstall, and D_BUSY→D_IDLE on dmem_done.
  - load_use = ex_mem_ren && ex_rd_idx!=0 && ((id_uses_rs1 && id_rs1_idx==ex_rd_idx) || (id_uses_rs2 && id_rs2_idx==ex_rd_idx)).
  - inst_avail = skid_valid || (imem_rvalid in F_WAIT).
- Priority is dstall > ex_redirect > load_use > fetch wait.
  - dstall: pc, IF-ID, ID-EX and EX-MEM enables = 0; mem_wb_en=1 with mem_wb_flush=1. A redirect is deferred, because ex_redirect is held by the frozen ID-EX.
  - ex_redirect: pc_en=1; if_id_flush=1; id_ex_flush=1; flush_cnt+1. Skid is cleared. Any in-flight fetch: F_WAIT→F_DROP, otherwise next state is F_REQ.
  - load_use: pc_en=0; if_id_en=0; id_ex_flush=1. Downstream enables stay 1.
  - Fetch wait (!inst_avail): pc_en=0; if_id_flush=1. Downstream enables stay 1.
  - Normal: all enables 1, flushes 0. fetch_inst comes from the skid if valid, else imem_rdata. pc_en=1.
- Fetch FSM:
  - F_REQ: imem_req=1 for one cycle, then F_WAIT. It is entered only when the PC register holds the address to fetch, i.e. one cycle after pc_en.
  - F_WAIT: on imem_rvalid:
    - If IF-ID accepts (if_id_en && !if_id_flush), go to F_REQ.
    - If IF-ID is stalled, write the instruction into the skid (skid_valid=1) and stay idle until the skid drains; then go to F_REQ.
  - F_DROP: imem_req=0; the next imem_rvalid is discarded (fetch_valid=0), then F_REQ.
- One fetch is outstanding at most. The skid holds exactly one entry. imem_rvalid outside F_WAIT/F_DROP is ignored.
- Counters: stall_cnt increments on every cycle with pc_en=0 after reset release; it wraps modulo 2^CNT_W. flush_cnt increments once per redirect and also wraps.
- Reset mid-operation: any outstanding fetch response after reset release is not expected; memory is reset by the same rst_n.

Decomposition:
- Shared package (new CPU_ctrl_pkg, or appended to decode): fetch_state_e {F_REQ, F_WAIT, F_DROP}; dmem_state_e {D_IDLE, D_BUSY}; packed struct stage_ctrl_t grouping the enable/flush bits.
- One natural sub-module: fetch_skid, holding the fetch FSM and the 1-entry skid buffer.
- The hazard and priority logic stays in the top module.

Test Plan:
- Load-use: lw x5 in EX (ex_mem_ren=1, ex_rd_idx=5) and ID reads rs1=5 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. With rd=0 there is no stall.
- Redirect in normal flow: ex_redirect=1 → if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt=1; next cycle imem_req=1.
- Redirect during F_WAIT: redirect, then imem_rvalid 3 cycles later with 0xDEADBEEF → that data is dropped (fetch_valid=0); F_REQ is reissued the following cycle.
- Skid: imem_rvalid with 0x00500293 during load_use → skid filled; next cycle fetch_inst=0x00500293, fetch_valid=1, and no new imem response is needed.
- Dmem wait: mem_access=1, dmem_done low for 4 cycles with ex_redirect=1 → four cycles of front enables=0 and mem_wb_flush=1. The redirect is taken in the cycle dmem_done=1 clears the stall.
- Async reset: rst_n low mid-F_WAIT → outputs reach reset values immediately without a clock edge; the first post-reset cycle has imem_req=1.
